// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops and a WIDTH-cycle
// shift-add multiplier behind a valid/ready handshake on both sides.
module mc_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] oper1,
  input  logic [WIDTH-1:0] oper2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zero,
  output logic             illegal,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_AND = 4'd3, OP_OR  = 4'd4,
    OP_XOR = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7, OP_SRA = 4'd8, OP_SLT = 4'd9
  } op_t;

  state_t                 state, state_next;
  logic                   accept;
  logic                   mul_last;
  logic [SHW-1:0]         cnt;
  logic [WIDTH-1:0]       mplier;
  logic [2*WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]     acc;
  logic [2*WIDTH-1:0]     acc_next;
  logic [WIDTH-1:0]       sum;
  logic [WIDTH-1:0]       diff;
  logic [SHW-1:0]         sh;
  logic [WIDTH-1:0]       alu_res;
  logic                   alu_ovf;
  logic                   alu_ill;

  assign accept    = in_valid && in_ready;
  assign mul_last  = (state == MUL) && (cnt == SHW'(WIDTH - 1));
  assign acc_next  = acc + (mplier[cnt] ? mcand : '0);
  assign sum       = oper1 + oper2;
  assign diff      = oper1 - oper2;
  assign sh        = oper2[SHW-1:0];
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake: a consumed result may be replaced on the same edge
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (control == OP_MUL) ? MUL : DONE;
      end
      MUL: begin
        if (mul_last) state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) state_next = (control == OP_MUL) ? MUL : DONE;
          else          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Single-cycle operations evaluated straight from the request operands
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (control)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (oper1[WIDTH-1] == oper2[WIDTH-1]) && (sum[WIDTH-1] != oper1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (oper1[WIDTH-1] != oper2[WIDTH-1]) && (diff[WIDTH-1] != oper1[WIDTH-1]);
      end
      OP_MUL: alu_res = '0;
      OP_AND: alu_res = oper1 & oper2;
      OP_OR:  alu_res = oper1 | oper2;
      OP_XOR: alu_res = oper1 ^ oper2;
      OP_SLL: alu_res = oper1 << sh;
      OP_SRL: alu_res = oper1 >> sh;
      OP_SRA: alu_res = $signed(oper1) >>> sh;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(oper1) < $signed(oper2))};
      default: alu_ill = 1'b1;
    endcase
  end

  // Datapath: capture on accept, one multiplier bit per MUL cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      mplier   <= '0;
      mcand    <= '0;
      acc      <= '0;
      result   <= '0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      illegal  <= 1'b0;
    end else if (accept) begin
      if (control == OP_MUL) begin
        cnt    <= '0;
        acc    <= '0;
        mplier <= oper2;
        mcand  <= {{WIDTH{1'b0}}, oper1};
      end else begin
        result   <= alu_res;
        overflow <= alu_ovf;
        zero     <= (alu_res == '0);
        illegal  <= alu_ill;
      end
    end else if (state == MUL) begin
      acc   <= acc_next;
      mcand <= mcand << 1;
      cnt   <= cnt + 1'b1;
      // The final partial product is folded straight into the result registers
      if (mul_last) begin
        cnt      <= '0;
        result   <= acc_next[WIDTH-1:0];
        overflow <= |acc_next[2*WIDTH-1:WIDTH];
        zero     <= (acc_next[WIDTH-1:0] == '0);
        illegal  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mc_alu.sv
module tb_mc_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  control;
  logic [31:0] oper1;
  logic [31:0] oper2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        zero;
  logic        illegal;
  logic        busy;

  mc_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .control(control), .oper1(oper1), .oper2(oper2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .overflow(overflow), .zero(zero),
    .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        zr;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic acc_seen = 1'b0;
  logic held = 1'b0;
  exp_t held_val;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -MAXS - 1;

  // Reference model: arithmetic on wide integers, straight from the opcode rules
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sbv, s;
    logic [63:0] p;
    int unsigned amt;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    amt = int'(b[4:0]);
    e   = '0;
    s   = 0;
    case (op)
      4'd0: begin s = sa + sbv; e.res = s[31:0]; e.ovf = (s > MAXS) || (s < MINS); end
      4'd1: begin s = sa - sbv; e.res = s[31:0]; e.ovf = (s > MAXS) || (s < MINS); end
      4'd2: begin p = 64'(a) * 64'(b); e.res = p[31:0]; e.ovf = (p >> 32) != 0; end
      4'd3: e.res = a & b;
      4'd4: e.res = a | b;
      4'd5: e.res = a ^ b;
      4'd6: e.res = a << amt;
      4'd7: e.res = a >> amt;
      4'd8: begin s = sa >>> amt; e.res = s[31:0]; end
      4'd9: e.res = (sa < sbv) ? 32'd1 : 32'd0;
      default: e.ill = 1'b1;
    endcase
    e.zr = (e.res == 32'd0);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard push: record the expected response for every accepted request
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      sb.push_back(model(control, oper1, oper2));
      acc_seen = 1'b1;
    end
  end

  // Monitor: compare on each output handshake, and check holding while stalled
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: unexpected output res=0x%0h with empty queue", result);
        end else begin
          e = sb.pop_front();
          if ({result, overflow, zero, illegal} !== e) begin
            errors++;
            $display("FAIL scoreboard: got res=0x%0h ovf=%0b z=%0b ill=%0b expected res=0x%0h ovf=%0b z=%0b ill=%0b",
                     result, overflow, zero, illegal, e.res, e.ovf, e.zr, e.ill);
          end
        end
        held = 1'b0;
      end else if (out_valid) begin
        if (held) begin
          checks++;
          if ({result, overflow, zero, illegal} !== held_val) begin
            errors++;
            $display("FAIL hold_stable: got 0x%0h expected 0x%0h", {result, overflow, zero, illegal}, held_val);
          end
        end
        held     = 1'b1;
        held_val = {result, overflow, zero, illegal};
      end else begin
        held = 1'b0;
      end
    end else begin
      held = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ok;
    ok       = 1'b0;
    control  = op;
    oper1    = a;
    oper2    = b;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 64'(ok), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_one(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] r, input logic o, input logic z, input logic il);
    int k;
    int stall;
    out_ready = 1'b1;
    send(op, a, b);
    k     = 0;
    stall = 0;
    while (k < 100) begin
      @(negedge clk);
      k++;
      if (out_valid) break;
      if (!in_ready) stall++;
    end
    chk({nm, "_latency"}, 64'(k), 64'(lat));
    chk({nm, "_result"}, 64'(result), 64'(r));
    chk({nm, "_flags"}, 64'({overflow, zero, illegal}), 64'({o, z, il}));
    if (op == 4'd2) chk({nm, "_stall"}, 64'(stall), 64'(lat - 1));
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0] op;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    control   = '0;
    oper1     = '0;
    oper2     = '0;
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({out_valid, overflow, zero, illegal, busy}), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    run_one("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    run_one("sub_zero", 4'd1, 32'd5, 32'd5, 1, 32'd0, 1'b0, 1'b1, 1'b0);
    run_one("slt_neg", 4'd9, 32'hFFFF_FFFF, 32'd1, 1, 32'd1, 1'b0, 1'b0, 1'b0);
    run_one("mul_big", 4'd2, 32'h0001_0000, 32'h0001_0000, 33, 32'd0, 1'b1, 1'b1, 1'b0);
    run_one("mul_small", 4'd2, 32'd7, 32'd6, 33, 32'd42, 1'b0, 1'b0, 1'b0);
    run_one("sra", 4'd8, 32'h8000_0000, 32'h0000_0024, 1, 32'hF800_0000, 1'b0, 1'b0, 1'b0);
    run_one("illegal", 4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 1, 32'd0, 1'b0, 1'b1, 1'b1);

    // Back-to-back after a stalled result
    out_ready = 1'b0;
    send(4'd4, 32'h0000_00F0, 32'h0000_0F00);
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_ready", 64'(in_ready), 64'd0);
      chk("stall_result", 64'(result), 64'h0FF0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(4'd5, 32'h0000_F0F0, 32'h0000_0FF0);
    @(negedge clk);
    chk("b2b_valid", 64'(out_valid), 64'd1);
    chk("b2b_result", 64'(result), 64'hFF00);
    @(posedge clk); #1;

    // Reset in the middle of a multiply
    send(4'd2, 32'd3, 32'd5);
    repeat (9) @(posedge clk);
    #2;
    chk("mul_busy", 64'({busy, in_ready}), 64'b10);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", 64'({out_valid, overflow, zero, illegal, busy}), 64'd0);
    chk("midreset_result", 64'(result), 64'd0);
    sb.delete();
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_midreset", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    run_one("add_after_reset", 4'd0, 32'd2, 32'd3, 1, 32'd5, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with random consumer backpressure
    acc_seen = 1'b0;
    repeat (3000) begin
      @(posedge clk); #1;
      if (in_valid && acc_seen) in_valid = 1'b0;
      acc_seen  = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && ($urandom_range(0, 2) != 0)) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'd2 && $urandom_range(0, 2) != 0) op = 4'd0;
        control  = op;
        oper1    = pick_val();
        oper2    = pick_val();
        in_valid = 1'b1;
      end
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
